// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared definitions for the register-file writeback path: MIPS datapath widths,
// the hardwired-zero register index and pointer sizing.
package rf_writeback_ctrl_pkg;

  localparam int unsigned MIPS_DATA_W = 32;
  localparam int unsigned MIPS_ADDR_W = 5;
  localparam int unsigned WB_DEPTH    = 4;

  localparam logic [MIPS_ADDR_W-1:0] ZERO_REG = 5'd0;

  // Pointer width for a power-of-two queue; never below one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Ordered dual-push, single-pop queue. The raw storage, valid mask and tail pointer
// are exported so the owner can search pending entries.
module wb_fifo
  import rf_writeback_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH,
  parameter int unsigned WIDTH = MIPS_ADDR_W + MIPS_DATA_W,
  localparam int unsigned PTR_W = ptr_w(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_push0,
  input  logic [WIDTH-1:0]            i_data0,
  input  logic                        i_push1,
  input  logic [WIDTH-1:0]            i_data1,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_head_data,
  output logic [CNT_W-1:0]            o_cnt,
  output logic [DEPTH-1:0][WIDTH-1:0] o_mem,
  output logic [DEPTH-1:0]            o_vld,
  output logic [PTR_W-1:0]            o_tail
);

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [DEPTH-1:0]            r_vld;
  logic [PTR_W-1:0]            r_head;
  logic [PTR_W-1:0]            r_tail;
  logic [CNT_W-1:0]            r_cnt;
  logic [PTR_W-1:0]            w_tail1;

  // i_push1 is only ever asserted together with i_push0, so it lands one slot later.
  assign w_tail1 = r_tail + PTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      // Pushes follow the pop so a full-queue slot reuse ends up valid.
      if (i_push0) r_vld[r_tail]  <= 1'b1;
      if (i_push1) r_vld[w_tail1] <= 1'b1;
      r_tail <= r_tail + PTR_W'(i_push0) + PTR_W'(i_push1);
      r_cnt  <= r_cnt + CNT_W'(i_push0) + CNT_W'(i_push1) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_tail]  <= i_data0;
    if (i_push1) r_mem[w_tail1] <= i_data1;
  end

  assign o_head_data = r_mem[r_head];
  assign o_cnt       = r_cnt;
  assign o_mem       = r_mem;
  assign o_vld       = r_vld;
  assign o_tail      = r_tail;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write initiator: merges ALU and MDU results in order, filters $0,
// issues one registered write per cycle and offers a bypass view of pending writes.
module rf_writeback_ctrl
  import rf_writeback_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH  = WB_DEPTH,
  parameter int unsigned DATA_W = MIPS_DATA_W,
  parameter int unsigned ADDR_W = MIPS_ADDR_W,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [ADDR_W-1:0] mdu_reg,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] byp_reg,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              zero_drop
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] ZeroReg = ADDR_W'(ZERO_REG);

  logic                        w_alu_enq;
  logic                        w_mdu_acc;
  logic                        w_mdu_enq;
  logic                        w_pop;
  logic                        w_drop;
  logic [CNT_W:0]              w_occ;
  logic                        w_push0;
  logic                        w_push1;
  logic [ENT_W-1:0]            w_data0;
  logic [ENT_W-1:0]            w_data1;
  logic [ENT_W-1:0]            w_head;
  logic [CNT_W-1:0]            w_cnt;
  logic [DEPTH-1:0][ENT_W-1:0] w_mem;
  logic [DEPTH-1:0]            w_vld;
  logic [PTR_W-1:0]            w_tail;
  logic [PTR_W-1:0]            w_idx;
  logic                        w_byp_hit;
  logic [DATA_W-1:0]           w_byp_data;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_zero_drop;

  assign w_pop     = (w_cnt != '0);
  assign w_alu_enq = alu_valid && (alu_reg != ZeroReg);

  // Occupancy after this edge's pop and ALU push; independent of mdu_valid.
  assign w_occ     = {1'b0, w_cnt} - (CNT_W + 1)'(w_pop) + (CNT_W + 1)'(w_alu_enq);
  assign mdu_ready = (w_occ < (CNT_W + 1)'(DEPTH));

  assign w_mdu_acc = mdu_valid && mdu_ready;
  assign w_mdu_enq = w_mdu_acc && (mdu_reg != ZeroReg);
  assign w_drop    = (alu_valid && (alu_reg == ZeroReg)) || (w_mdu_acc && (mdu_reg == ZeroReg));

  // Compact surviving pushes so slot 0 is always filled first, ALU ahead of MDU.
  assign w_push0 = w_alu_enq || w_mdu_enq;
  assign w_push1 = w_alu_enq && w_mdu_enq;
  assign w_data0 = w_alu_enq ? {alu_reg, alu_data} : {mdu_reg, mdu_data};
  assign w_data1 = {mdu_reg, mdu_data};

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_wb_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push0     (w_push0),
    .i_data0     (w_data0),
    .i_push1     (w_push1),
    .i_data1     (w_data1),
    .i_pop       (w_pop),
    .o_head_data (w_head),
    .o_cnt       (w_cnt),
    .o_mem       (w_mem),
    .o_vld       (w_vld),
    .o_tail      (w_tail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_zero_drop  <= 1'b0;
    end else begin
      r_reg_write <= w_pop;
      r_zero_drop <= w_drop;
      if (w_pop) begin
        r_write_reg  <= w_head[ENT_W-1:DATA_W];
        r_write_data <= w_head[DATA_W-1:0];
      end
    end
  end

  // Walk oldest to newest so the last match (the newest write) wins.
  always_comb begin
    w_byp_hit  = 1'b0;
    w_byp_data = '0;
    w_idx      = '0;
    if (byp_reg != ZeroReg) begin
      if (r_reg_write && (r_write_reg == byp_reg)) begin
        w_byp_hit  = 1'b1;
        w_byp_data = r_write_data;
      end
      for (int k = DEPTH; k >= 1; k--) begin
        w_idx = w_tail - PTR_W'(k);
        if (w_vld[w_idx] && (w_mem[w_idx][ENT_W-1:DATA_W] == byp_reg)) begin
          w_byp_hit  = 1'b1;
          w_byp_data = w_mem[w_idx][DATA_W-1:0];
        end
      end
    end
  end

  assign regWrite  = r_reg_write;
  assign writeReg  = r_write_reg;
  assign writeData = r_write_data;
  assign zero_drop = r_zero_drop;
  assign pend_cnt  = w_cnt;
  assign byp_hit   = w_byp_hit;
  assign byp_data  = w_byp_data;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed scenarios and random traffic, each cycle
// compared against an in-order queue model of pending writes.
module tb_rf_writeback_ctrl;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_reg = '0;
  logic [DW-1:0] alu_data = '0;
  logic          mdu_valid = 1'b0;
  logic          mdu_ready;
  logic [AW-1:0] mdu_reg = '0;
  logic [DW-1:0] mdu_data = '0;
  logic          regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;
  logic [AW-1:0] byp_reg = '0;
  logic          byp_hit;
  logic [DW-1:0] byp_data;
  logic [CW-1:0] pend_cnt;
  logic          zero_drop;

  rf_writeback_ctrl #(
    .DEPTH  (DEPTH),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_reg   (mdu_reg),
    .mdu_data  (mdu_data),
    .regWrite  (regWrite),
    .writeReg  (writeReg),
    .writeData (writeData),
    .byp_reg   (byp_reg),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data),
    .pend_cnt  (pend_cnt),
    .zero_drop (zero_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  // Reference: ordered list of not-yet-issued writes plus the current write-port contents.
  ent_t          q[$];
  logic          m_rw = 1'b0;
  logic [AW-1:0] m_wr = '0;
  logic [DW-1:0] m_wd = '0;
  logic          m_zd = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int max_cnt = 0;
  int ready_low = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                       input logic [AW-1:0] br);
    int   sz;
    logic pop;
    logic aenq;
    logic rdy;
    logic hit;
    logic [DW-1:0] bd;
    ent_t e;
    @(negedge clk);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mdu_valid = mv; mdu_reg = mr; mdu_data = md;
    byp_reg = br;
    #1;
    sz   = q.size();
    pop  = (sz > 0);
    aenq = av && (ar != 0);
    rdy  = (sz - int'(pop) + int'(aenq)) < DEPTH;
    hit  = 1'b0;
    bd   = '0;
    if (br != 0) begin
      for (int i = sz - 1; i >= 0; i--)
        if (!hit && q[i].r == br) begin hit = 1'b1; bd = q[i].d; end
      if (!hit && m_rw && m_wr == br) begin hit = 1'b1; bd = m_wd; end
    end
    chk("mdu_ready", 32'(mdu_ready), 32'(rdy));
    chk("byp_hit", 32'(byp_hit), 32'(hit));
    chk("byp_data", byp_data, bd);
    if (!mdu_ready) ready_low++;
    if (pop) begin
      e = q.pop_front();
      m_rw = 1'b1; m_wr = e.r; m_wd = e.d;
    end else begin
      m_rw = 1'b0;
    end
    if (aenq) q.push_back('{r: ar, d: ad});
    if (mv && rdy && mr != 0) q.push_back('{r: mr, d: md});
    m_zd = (av && ar == 0) || (mv && rdy && mr == 0);
    @(posedge clk);
    #1;
    chk("regWrite", 32'(regWrite), 32'(m_rw));
    chk("writeReg", 32'(writeReg), 32'(m_wr));
    chk("writeData", writeData, m_wd);
    chk("pend_cnt", 32'(pend_cnt), 32'(q.size()));
    chk("zero_drop", 32'(zero_drop), 32'(m_zd));
    if (int'(pend_cnt) > max_cnt) max_cnt = int'(pend_cnt);
  endtask

  task automatic idle(input int n, input logic [AW-1:0] br);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, br);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    alu_valid = 1'b0; mdu_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_pend_cnt", 32'(pend_cnt), 32'd0);
    chk("rst_zero_drop", 32'(zero_drop), 32'd0);
    q.delete();
    m_rw = 1'b0; m_wr = '0; m_wd = '0; m_zd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #10;
    chk("init_regWrite", 32'(regWrite), 32'd0);
    chk("init_writeReg", 32'(writeReg), 32'd0);
    chk("init_writeData", writeData, 32'd0);
    chk("init_pend_cnt", 32'(pend_cnt), 32'd0);
    chk("init_zero_drop", 32'(zero_drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 5'd0);

    // Single ALU write, then watch it issue exactly once.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd5);
    idle(3, 5'd5);

    // Same-cycle ALU and MDU to one register: order and newest-wins bypass.
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3);
    idle(4, 5'd3);

    // Saturation: both sources every cycle for 10 cycles.
    max_cnt = 0;
    ready_low = 0;
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 5'(i + 1), 32'hA000 + 32'(i), 1'b1, 5'(i + 11), 32'hB000 + 32'(i), 5'(i + 1));
    chk("sat_max_cnt", 32'(max_cnt), 32'(DEPTH));
    chk("sat_ready_low", 32'(ready_low > 0), 32'd1);
    idle(DEPTH + 2, 5'd12);

    // $0 filtering from both sources.
    cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 5'd0);
    cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 5'd0);
    idle(2, 5'd0);

    // Reset with three entries pending.
    cycle(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202, 5'd2);
    cycle(1'b1, 5'd3, 32'h303, 1'b1, 5'd4, 32'h404, 5'd1);
    chk("pre_rst_pend", 32'(pend_cnt), 32'd3);
    mid_reset();
    idle(4, 5'd3);

    // Random traffic with a narrow register range to force collisions and $0 hits.
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 10) < 6, 5'($urandom_range(0, 7)), $urandom,
            ($urandom % 10) < 6, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
    idle(DEPTH + 2, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
